// File: rtl/tdm_demux.sv
// Time-division demultiplexer: recovers N_CH slot-ordered channels from one shared lane.
// Optional idle-gap timeout inside a frame is enabled by defining TDM_DEMUX_TIMEOUT_EN.
module tdm_demux #(
    parameter int unsigned N_CH    = 4,
    parameter int unsigned W       = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [W-1:0]      din,
    input  logic              din_valid,
    input  logic              frame_sync,
    output logic [N_CH*W-1:0] ch_data,
    output logic              out_valid,
    output logic              sync_err
);

    localparam int unsigned   SW       = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam logic [SW-1:0] LastSlot = SW'(N_CH - 1);

    typedef enum logic [0:0] {StHunt, StRecv} state_e;

    state_e              state_q, state_d;
    logic [SW-1:0]       slot_q, slot_d;
    logic [N_CH*W-1:0]   slot_buf_q, frame_next;
    logic                sync_beat, data_beat;
    logic                complete, slip, tmo, gap_hit;

    if (N_CH == 0 || TIMEOUT == 0) begin : g_param_check
        $error("tdm_demux: N_CH and TIMEOUT must be at least 1");
    end

`ifdef TDM_DEMUX_TIMEOUT_EN
    localparam int unsigned GW = $clog2(TIMEOUT + 1);
    logic [GW-1:0] gap_q;

    // Fires on the TIMEOUT-th consecutive idle cycle; any beat that cycle wins.
    assign gap_hit = !din_valid && (gap_q == GW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            gap_q <= '0;
        end else if (state_q != StRecv || din_valid || gap_hit) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_q + 1'b1;
        end
    end
`else
    assign gap_hit = 1'b0;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StHunt;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StHunt:  if (sync_beat && !complete) state_d = StRecv;
            StRecv:  if (complete || tmo) state_d = StHunt;
            default: state_d = StHunt;
        endcase
    end

    // Beat decode and event outputs
    always_comb begin
        sync_beat = din_valid & frame_sync;
        data_beat = din_valid & ~frame_sync;
        complete  = 1'b0;
        slip      = 1'b0;
        tmo       = 1'b0;
        unique case (state_q)
            StHunt: complete = sync_beat && (N_CH == 1);
            StRecv: begin
                complete = data_beat && (slot_q == LastSlot);
                slip     = sync_beat;
                tmo      = gap_hit;
            end
            default: ;
        endcase
    end

    // Buffer write and slot counter update
    always_comb begin
        frame_next = slot_buf_q;
        slot_d     = slot_q;
        if (sync_beat) begin
            // A sync always restarts the frame, discarding any partial capture.
            frame_next        = '0;
            frame_next[W-1:0] = din;
            slot_d            = SW'(1);
        end else if (data_beat && state_q == StRecv) begin
            frame_next[int'(slot_q)*W +: W] = din;
            slot_d                          = slot_q + 1'b1;
        end
        if (complete || tmo) begin
            slot_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            slot_q     <= '0;
            slot_buf_q <= '0;
            ch_data    <= '0;
            out_valid  <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            slot_q     <= slot_d;
            slot_buf_q <= frame_next;
            if (complete) begin
                ch_data <= frame_next;
            end
            out_valid  <= complete;
            sync_err   <= slip | tmo;
        end
    end

endmodule
